// File: rtl/tmr_error_pkg.sv
// rtl/tmr_error_pkg.sv - shared state enum and bit-vector helpers for the TMR error collector
package tmr_error_pkg;

  typedef enum logic [1:0] {
    TE_IDLE = 2'd0,
    TE_ERR  = 2'd1,
    TE_CLR  = 2'd2
  } te_state_t;

  // Number of set bits in a channel vector (up to 64 channels).
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [5:0] lowest_set(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) begin
        idx = 6'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tmr_error_sync.sv
// rtl/tmr_error_sync.sv - per-bit two-flop synchronizer for asynchronous error flags
module tmr_error_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops per bit; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmr_error_collector.sv
// rtl/tmr_error_collector.sv - TMR error record (count, sticky map, first index, irq); option TMR_ERROR_SYNC_EN
module tmr_error_collector
  import tmr_error_pkg::*;
#(
  parameter int N     = 10,
  parameter int CNT_W = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     err_i,
  input  logic [CNT_W-1:0] thr_i,
  input  logic             clr_req_i,
  output logic             clr_ack_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [N-1:0]     err_map_o,
  output logic [IDX_W-1:0] first_idx_o,
  output logic             first_vld_o,
  output logic             irq_o
);

  // Sum is wide enough to hold a saturated count plus a full 64-channel burst.
  localparam int SUM_W = CNT_W + 8;
  localparam logic [SUM_W-1:0] CNT_MAX = {8'd0, {CNT_W{1'b1}}};

  logic [N-1:0]     err_s;
  logic [N-1:0]     err_q;
  logic [N-1:0]     rise;
  logic             clr_req_q;
  logic             clr_take;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;
  te_state_t        state;
  te_state_t        state_nxt;

`ifdef TMR_ERROR_SYNC_EN
  tmr_error_sync #(.W(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (err_i),
    .q   (err_s)
  );
`else
  assign err_s = err_i;
`endif

  // Previous flag values; reset to 0 so a flag already high at release counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_s;
    end
  end

  assign rise = err_s & ~err_q;

  // Remember the last request level so a held request is only taken once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_req_q <= 1'b0;
    end else begin
      clr_req_q <= clr_req_i;
    end
  end

  assign clr_take = clr_req_i & ~clr_req_q & (state != TE_CLR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clear requests win over new events; CLR lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      TE_IDLE: begin
        if (clr_take) begin
          state_nxt = TE_CLR;
        end else if (rise != '0) begin
          state_nxt = TE_ERR;
        end
      end
      TE_ERR: begin
        if (clr_take) begin
          state_nxt = TE_CLR;
        end
      end
      TE_CLR: begin
        state_nxt = (rise != '0) ? TE_ERR : TE_IDLE;
      end
      default: begin
        state_nxt = TE_IDLE;
      end
    endcase
  end

  assign cnt_sum = SUM_W'(err_cnt_o) + SUM_W'(popcount(64'(rise)));
  assign cnt_nxt = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  // Record update: wipe on clear entry, otherwise accumulate (including during CLR).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_o   <= '0;
      err_map_o   <= '0;
      first_idx_o <= '0;
      first_vld_o <= 1'b0;
    end else if (clr_take) begin
      err_cnt_o   <= '0;
      err_map_o   <= '0;
      first_idx_o <= '0;
      first_vld_o <= 1'b0;
    end else begin
      err_cnt_o <= cnt_nxt;
      err_map_o <= err_map_o | rise;
      if (!first_vld_o && (rise != '0)) begin
        first_idx_o <= IDX_W'(lowest_set(64'(rise)));
        first_vld_o <= 1'b1;
      end
    end
  end

  assign clr_ack_o = (state == TE_CLR);
  assign irq_o     = (thr_i != '0) && (err_cnt_o >= thr_i);

endmodule

// File: tb/tb_tmr_error_collector.sv
// tb/tb_tmr_error_collector.sv - self-checking bench for tmr_error_collector
module tb_tmr_error_collector;

  localparam int N       = 10;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef TMR_ERROR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic [N-1:0]     err_i;
  logic [CNT_W-1:0] thr_i;
  logic             clr_req_i;
  logic             clr_ack_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [N-1:0]     err_map_o;
  logic [IDX_W-1:0] first_idx_o;
  logic             first_vld_o;
  logic             irq_o;

  tmr_error_collector #(.N(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .err_i       (err_i),
    .thr_i       (thr_i),
    .clr_req_i   (clr_req_i),
    .clr_ack_o   (clr_ack_o),
    .err_cnt_o   (err_cnt_o),
    .err_map_o   (err_map_o),
    .first_idx_o (first_idx_o),
    .first_vld_o (first_vld_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the error record.
  int           m_cnt;
  logic [N-1:0] m_map;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_d1;
  logic [N-1:0] m_d2;
  int           m_idx;
  bit           m_vld;
  bit           m_clr;
  bit           m_req_prev;

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] es;
    logic [N-1:0] rs;
    if (rst) begin
      m_cnt = 0; m_map = '0; m_prev = '0; m_d1 = '0; m_d2 = '0;
      m_idx = 0; m_vld = 0; m_clr = 0; m_req_prev = 0;
    end else begin
      es = (LAT == 3) ? m_d2 : err_i;
      m_d2 = m_d1;
      m_d1 = err_i;
      rs = es & ~m_prev;
      m_prev = es;
      if (clr_req_i && !m_req_prev && !m_clr) begin
        m_cnt = 0; m_map = '0; m_idx = 0; m_vld = 0; m_clr = 1;
      end else begin
        m_clr = 0;
        m_cnt = m_cnt + $countones(rs);
        if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        m_map = m_map | rs;
        if (!m_vld && rs != '0) begin
          for (int j = N - 1; j >= 0; j--) if (rs[j]) m_idx = j;
          m_vld = 1;
        end
      end
      m_req_prev = clr_req_i;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_cnt", err_cnt_o, m_cnt);
    chk("m_map", err_map_o, m_map);
    chk("m_vld", first_vld_o, m_vld);
    chk("m_idx", first_idx_o, m_idx);
    chk("m_ack", clr_ack_o, m_clr);
    chk("m_irq", irq_o, (thr_i != 0) && (m_cnt >= thr_i));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    err_i = '0;
    clr_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int acks;
    rst = 1'b1; err_i = '0; thr_i = '0; clr_req_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_map", err_map_o, 0);
    chk("rst_vld", first_vld_o, 0);
    chk("rst_ack", clr_ack_o, 0);
    chk("rst_irq", irq_o, 0);

    // single pulse on bit 3, measure event latency
    err_i = 10'h008;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      lat++;
      if (lat == 1) err_i = '0;
      if (err_cnt_o != 0) break;
    end
    chk("latency", lat, LAT);
    repeat (4) tick();
    chk("p3_cnt", err_cnt_o, 1);
    chk("p3_map", err_map_o, 10'h008);
    chk("p3_idx", first_idx_o, 3);
    chk("p3_vld", first_vld_o, 1);

    // simultaneous rises on 2,5,9 then a later rise on 0
    do_reset();
    err_i = 10'h224;
    repeat (4) tick();
    chk("multi_cnt", err_cnt_o, 3);
    chk("multi_idx", first_idx_o, 2);
    chk("multi_map", err_map_o, 10'h224);
    err_i = 10'h225;
    repeat (4) tick();
    chk("late0_cnt", err_cnt_o, 4);
    chk("late0_idx", first_idx_o, 2);
    chk("late0_map", err_map_o, 10'h225);

    // saturation at 15 with 20 pulses
    do_reset();
    for (int k = 0; k < 20; k++) begin
      err_i = 10'h002; tick();
      err_i = '0;      tick();
    end
    repeat (4) tick();
    chk("sat_cnt", err_cnt_o, 15);
    chk("sat_map", err_map_o, 10'h002);
    repeat (3) tick();
    chk("sat_hold", err_cnt_o, 15);

    // threshold interrupt then held clear request
    do_reset();
    thr_i = 4'd2;
    err_i = 10'h010; tick();
    err_i = '0;      tick();
    err_i = 10'h040; tick();
    err_i = '0;
    repeat (4) tick();
    chk("irq_cnt", err_cnt_o, 2);
    chk("irq_on", irq_o, 1);
    thr_i = 4'd0; tick();
    chk("irq_thr0", irq_o, 0);
    thr_i = 4'd3; tick();
    chk("irq_thr3", irq_o, 0);
    thr_i = 4'd2; tick();
    clr_req_i = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      acks += int'(clr_ack_o);
    end
    clr_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      acks += int'(clr_ack_o);
    end
    chk("clr_acks", acks, 1);
    chk("clr_cnt", err_cnt_o, 0);
    chk("clr_map", err_map_o, 0);
    chk("clr_vld", first_vld_o, 0);
    chk("clr_irq", irq_o, 0);

    // edge on bit 7 during the CLR cycle survives the clear
    err_i = 10'h010; tick();
    err_i = '0; tick(); tick();
    clr_req_i = 1'b1;
    tick();
    chk("clr7_ack", clr_ack_o, 1);
    chk("clr7_zero", err_cnt_o, 0);
    err_i = 10'h080;
    tick();
    clr_req_i = 1'b0;
    repeat (4) tick();
    chk("clr7_cnt", err_cnt_o, 1);
    chk("clr7_map", err_map_o, 10'h080);
    chk("clr7_idx", first_idx_o, 7);

    // asynchronous reset mid-record; bit 7 still high counts once after release
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", err_cnt_o, 0);
    chk("arst_map", err_map_o, 0);
    chk("arst_vld", first_vld_o, 0);
    chk("arst_irq", irq_o, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("relhigh_cnt", err_cnt_o, 1);

    // asynchronous reset during CLR drops the ack
    clr_req_i = 1'b1;
    tick();
    chk("mclr_ack", clr_ack_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mclr_ack_rst", clr_ack_o, 0);
    chk("mclr_cnt_rst", err_cnt_o, 0);
    clr_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mclr_noack", clr_ack_o, 0);
    err_i = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tmr_error_collector.md
# tmr_error_collector

Collects the per-instance `tmrError` flags produced by triplicated sub-blocks and turns them into a host-readable error record. It sits directly downstream of the voter error outputs: N instance flags in, one saturating event count, a sticky per-channel map, a first-error index and a threshold interrupt out. Intended to be instantiated once per top-level, replacing ad-hoc `wor` aggregation of error nets.

## Interface
- `N`, 10, number of error channels, 1..64.
- `CNT_W`, 16, width of the event counter.
- `IDX_W`, `$clog2(N)` (min 1), width of the channel-index output.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `err_i`  in  N  per-instance tmrError flags, level; bit j comes from instance j.
- `thr_i`  in  CNT_W  interrupt threshold; sampled every cycle.
- `clr_req_i`  in  1  clear request, level, held until ack.
- `clr_ack_o`  out  1  one-cycle clear acknowledge.
- `err_cnt_o`  out  CNT_W  saturating count of error events.
- `err_map_o`  out  N  sticky set of channels that have flagged.
- `first_idx_o`  out  IDX_W  lowest channel in the first event.
- `first_vld_o`  out  1  `first_idx_o` is valid.
- `irq_o`  out  1  level interrupt, `err_cnt_o >= thr_i` and `thr_i != 0`.

## Operation
- Event: rising edge of `err_i[j]` against its registered previous value. The previous value resets to 0, so an input already high at reset release counts once.
- Per cycle, `rise = err_s & ~err_q`. The counter adds `popcount(rise)` and saturates at `2**CNT_W-1`. It never wraps.
- `err_map_o |= rise`.
- On the first cycle with `rise != 0` while `first_vld_o == 0`: `first_idx_o` captures the lowest set bit of `rise`, and `first_vld_o` goes to 1.
- FSM states:
  - IDLE: no event since reset or clear. Goes to ERR when `rise != 0`.
  - ERR: holds the record.
  - CLR: entered from IDLE or ERR when `clr_req_i == 1`. Stays one cycle, then returns to IDLE, or to ERR if `rise != 0` during CLR.
- Clear on entry to CLR: `err_cnt_o`, `err_map_o`, `first_vld_o` and `first_idx_o` become 0. `clr_ack_o` is 1 during the CLR cycle only.
- In the CLR cycle, new edges are accumulated into the freshly cleared record, so no event is lost.
- A new request is accepted only after `clr_req_i` has been seen low for at least one cycle. This is edge-qualified, so a request held high causes exactly one clear.
- `irq_o` is combinational from registered `err_cnt_o` and `thr_i`. It drops in the cycle after the clear takes effect.

## Timing
- Reset values: all outputs are 0; the FSM is in IDLE.
- Without sync, `err_s = err_i`. Latency from `err_i` rising to `err_cnt_o`/`err_map_o` updating is 1 cycle.
- `first_idx_o` and `first_vld_o` update in the same cycle as the count.
- `clr_req_i` rises in cycle t → CLR in t+1 (`clr_ack_o` = 1, outputs read 0) → record includes any edges of t+1 at t+2.
- Reset is asserted asynchronously, is honoured mid-clear, and drops any pending ack.

## Configuration
- `TMR_ERROR_SYNC_EN`:
  - Defined: `err_i` passes through a 2-flop synchronizer per bit before edge detection. Event latency becomes 3 cycles.
  - Undefined: `err_i` is assumed to be synchronous to `clk`, and latency is 1 cycle.
- The clear and interrupt paths are identical in both builds.

## Structure
- Package `tmr_error_pkg`: the FSM state enum (`TE_IDLE`, `TE_ERR`, `TE_CLR`), a popcount function, and a lowest-set-bit index function.
- Sub-module `tmr_error_sync`: N-bit 2-flop synchronizer, instantiated only under `TMR_ERROR_SYNC_EN`.
- All logic is single clock domain after synchronization.

## Test plan
- Reset with `err_i=0`, then pulse `err_i[3]` for 1 cycle → `err_cnt_o=1`, `err_map_o=0x008`, `first_idx_o=3`, `first_vld_o=1`.
- Same cycle, raise bits 2, 5 and 9 → `err_cnt_o=3`, `first_idx_o=2`. A later rise on bit 0 gives `err_cnt_o=4` and `first_idx_o` stays 2.
- `CNT_W=4`, 20 single-bit pulses → `err_cnt_o` saturates at 15 and stays there.
- `thr_i=2`, two events → `irq_o=1` at the second update. Then `clr_req_i` held for 5 cycles → exactly one `clr_ack_o` pulse, outputs 0, `irq_o=0`.
- Edge on bit 7 in the CLR cycle → after the clear, `err_cnt_o=1` and `err_map_o=0x080`.
- `rst` asserted mid-record and mid-CLR → all outputs 0 asynchronously, no ack. Rebuild with `TMR_ERROR_SYNC_EN` and check 3-cycle event latency.
